// File: rtl/gcd_host.sv
// gcd_host: feeds operand pairs to ifc_gcd A/B FIFOs, returns (a,b,y) in issue order; optional watchdog via GCD_HOST_TIMEOUT_EN.
// Latency: issue is combinational (same cycle); response valid the cycle after y_en_o.
// Backpressure: commands stall on A/B full or MAX_OUTST outstanding; Y pops only when the response register can take it.
module gcd_host #(
    parameter int DW          = 4,
    parameter int MAX_OUTST   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [DW-1:0]                  cmd_a_i,
    input  logic [DW-1:0]                  cmd_b_i,
    output logic                           a_en_o,
    output logic                           b_en_o,
    output logic [DW-1:0]                  a_data_o,
    output logic [DW-1:0]                  b_data_o,
    input  logic                           a_rdy_i,
    input  logic                           b_rdy_i,
    input  logic                           y_rdy_i,
    input  logic [DW-1:0]                  y_data_i,
    output logic                           y_en_o,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [DW-1:0]                  rsp_a_o,
    output logic [DW-1:0]                  rsp_b_o,
    output logic [DW-1:0]                  rsp_y_o,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           timeout_o
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = $clog2(MAX_OUTST+1);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t         track_mem [MAX_OUTST];
    pair_t         track_head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] outst_q;
    logic [DW-1:0] a_last;
    logic [DW-1:0] b_last;
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_a_q;
    logic [DW-1:0] rsp_b_q;
    logic [DW-1:0] rsp_y_q;
    logic          issue;
    logic          retire;
    logic          track_nonempty;

    // The tracking FIFO holds exactly the outstanding pairs, so its occupancy is outst_q.
    assign track_nonempty = (outst_q != '0);
    assign track_head     = track_mem[rd_ptr];

    assign cmd_ready_o = a_rdy_i & b_rdy_i & (outst_q < CW'(MAX_OUTST));
    assign issue       = cmd_valid_i & cmd_ready_o;
    assign a_en_o      = issue;
    assign b_en_o      = issue;
    assign a_data_o    = issue ? cmd_a_i : a_last;
    assign b_data_o    = issue ? cmd_b_i : b_last;

    assign y_en_o = y_rdy_i & track_nonempty & (!rsp_valid_q | rsp_ready_i);
    assign retire = y_en_o;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_a_o     = rsp_a_q;
    assign rsp_b_o     = rsp_b_q;
    assign rsp_y_o     = rsp_y_q;
    assign outst_o     = outst_q;

    always_ff @(posedge clk_i) begin
        if (issue) begin
            track_mem[wr_ptr] <= '{a: cmd_a_i, b: cmd_b_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            outst_q <= '0;
            a_last  <= '0;
            b_last  <= '0;
        end else begin
            if (issue) begin
                wr_ptr <= wr_ptr + 1'b1;
                a_last <= cmd_a_i;
                b_last <= cmd_b_i;
            end
            if (retire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({issue, retire})
                2'b10:   outst_q <= outst_q + 1'b1;
                2'b01:   outst_q <= outst_q - 1'b1;
                default: outst_q <= outst_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_a_q     <= '0;
            rsp_b_q     <= '0;
            rsp_y_q     <= '0;
        end else if (retire) begin
            rsp_valid_q <= 1'b1;
            rsp_a_q     <= track_head.a;
            rsp_b_q     <= track_head.b;
            rsp_y_q     <= y_data_i;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef GCD_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC+1);

    logic [TW-1:0] wd_cnt;
    logic          timeout_q;

    // Counter saturates at the limit; the flag is sticky until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (retire || (outst_q == '0)) begin
                wd_cnt <= '0;
            end else if (wd_cnt != TW'(TIMEOUT_CYC)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt == TW'(TIMEOUT_CYC)) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_host.sv
// Directed bench for gcd_host with a behavioural ifc_gcd model behind the A/B/Y ports.
module tb_gcd_host;
    localparam int DW = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [DW-1:0] cmd_a_i;
    logic [DW-1:0] cmd_b_i;
    logic          a_en_o;
    logic          b_en_o;
    logic [DW-1:0] a_data_o;
    logic [DW-1:0] b_data_o;
    logic          a_rdy_i;
    logic          b_rdy_i;
    logic          y_rdy_i;
    logic [DW-1:0] y_data_i;
    logic          y_en_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_a_o;
    logic [DW-1:0] rsp_b_o;
    logic [DW-1:0] rsp_y_o;
    logic [2:0]    outst_o;
    logic          timeout_o;

    gcd_host #(.DW(DW), .MAX_OUTST(4), .TIMEOUT_CYC(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
        .a_en_o(a_en_o), .b_en_o(b_en_o),
        .a_data_o(a_data_o), .b_data_o(b_data_o),
        .a_rdy_i(a_rdy_i), .b_rdy_i(b_rdy_i),
        .y_rdy_i(y_rdy_i), .y_data_i(y_data_i), .y_en_o(y_en_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_a_o(rsp_a_o), .rsp_b_o(rsp_b_o), .rsp_y_o(rsp_y_o),
        .outst_o(outst_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Accelerator model: results appear in the Y FIFO the cycle after A/B are written.
    function automatic logic [DW-1:0] gcd_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x = a;
        logic [DW-1:0] y = b;
        logic [DW-1:0] t;
        for (int i = 0; i < 32; i++) begin
            if (y != 0) begin
                t = x % y;
                x = y;
                y = t;
            end
        end
        return x;
    endfunction

    logic [DW-1:0] acc_y [64];
    int            acc_wr = 0;
    int            acc_rd = 0;
    logic          y_gate;
    logic          y_force;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_wr <= 0;
            acc_rd <= 0;
        end else begin
            if (a_en_o && b_en_o) begin
                acc_y[acc_wr % 64] <= gcd_f(a_data_o, b_data_o);
                acc_wr <= acc_wr + 1;
            end
            if (y_en_o && !y_force) acc_rd <= acc_rd + 1;
        end
    end

    always_comb begin
        y_rdy_i  = y_force | (y_gate && (acc_wr != acc_rd));
        y_data_i = y_force ? 4'd5 : acc_y[acc_rd % 64];
    end

    logic [DW-1:0] got_a [64];
    logic [DW-1:0] got_b [64];
    logic [DW-1:0] got_y [64];
    int            got_n = 0;

    always @(posedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            got_a[got_n % 64] <= rsp_a_o;
            got_b[got_n % 64] <= rsp_b_o;
            got_y[got_n % 64] <= rsp_y_o;
            got_n <= got_n + 1;
        end
    end

    logic [DW-1:0] tv_a [8] = '{4'd12, 4'd9, 4'd15, 4'd7, 4'd14, 4'd0, 4'd8,  4'd10};
    logic [DW-1:0] tv_b [8] = '{4'd8,  4'd6, 4'd10, 4'd3, 4'd7,  4'd5, 4'd12, 4'd4};
    logic [DW-1:0] tv_y [8] = '{4'd4,  4'd3, 4'd5,  4'd1, 4'd7,  4'd5, 4'd4,  4'd2};

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        cmd_valid_i = 1'b1;
        cmd_a_i     = a;
        cmd_b_i     = b;
        @(negedge clk_i);
        while (!cmd_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (got_n < target && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (got_n < target) check("rsp_timeout", 32'(got_n), 32'(target));
    endtask

    task automatic check_got(input string tag, input int idx,
                             input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] y);
        check({tag, "_a"}, 32'(got_a[idx % 64]), 32'(a));
        check({tag, "_b"}, 32'(got_b[idx % 64]), 32'(b));
        check({tag, "_y"}, 32'(got_y[idx % 64]), 32'(y));
    endtask

    int base;

    initial begin
        rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_a_i = '0; cmd_b_i = '0;
        a_rdy_i = 1'b0; b_rdy_i = 1'b0; rsp_ready_i = 1'b1; y_gate = 1'b0; y_force = 1'b0;
        #3;
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_outst",     32'(outst_o), 0);
        check("rst_timeout",   32'(timeout_o), 0);
        check("rst_a_data",    32'(a_data_o), 0);
        check("rst_b_data",    32'(b_data_o), 0);
        check("rst_cmd_ready", 32'(cmd_ready_o), 0);
        check("rst_y_en",      32'(y_en_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1; a_rdy_i = 1'b1; b_rdy_i = 1'b1;

        // Single command 12/8 -> 4
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b1; cmd_a_i = 4'd12; cmd_b_i = 4'd8;
        @(negedge clk_i);
        check("t1_a_en",     32'(a_en_o), 1);
        check("t1_b_en",     32'(b_en_o), 1);
        check("t1_a_data",   32'(a_data_o), 12);
        check("t1_b_data",   32'(b_data_o), 8);
        check("t1_outst0",   32'(outst_o), 0);
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("t1_a_en_off", 32'(a_en_o), 0);
        check("t1_a_hold",   32'(a_data_o), 12);
        check("t1_outst1",   32'(outst_o), 1);
        check("t1_no_rsp",   32'(rsp_valid_o), 0);
        @(posedge clk_i);
        #1 y_gate = 1'b1;
        @(negedge clk_i);
        check("t1_y_en",     32'(y_en_o), 1);
        check("t1_rsp_pre",  32'(rsp_valid_o), 0);
        @(negedge clk_i);
        check("t1_rsp_valid", 32'(rsp_valid_o), 1);
        check("t1_rsp_a",    32'(rsp_a_o), 12);
        check("t1_rsp_b",    32'(rsp_b_o), 8);
        check("t1_rsp_y",    32'(rsp_y_o), 4);
        check("t1_outst2",   32'(outst_o), 0);
        @(negedge clk_i);
        check("t1_rsp_clr",  32'(rsp_valid_o), 0);

        // B FIFO full blocks issue of both halves
        @(posedge clk_i);
        #1 b_rdy_i = 1'b0; cmd_valid_i = 1'b1; cmd_a_i = 4'd3; cmd_b_i = 4'd9;
        base = got_n;
        repeat (3) begin
            @(negedge clk_i);
            check("t3_cmd_ready", 32'(cmd_ready_o), 0);
            check("t3_a_en",      32'(a_en_o), 0);
            check("t3_b_en",      32'(b_en_o), 0);
        end
        @(posedge clk_i);
        #1 b_rdy_i = 1'b1;
        @(negedge clk_i);
        check("t3_a_en_go", 32'(a_en_o), 1);
        check("t3_b_en_go", 32'(b_en_o), 1);
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
        wait_rsp(base + 1);
        check_got("t3", base, 4'd3, 4'd9, 4'd3);

        // Unsolicited result is never popped
        @(posedge clk_i);
        #1 y_force = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("t4_y_en",      32'(y_en_o), 0);
            check("t4_rsp_valid", 32'(rsp_valid_o), 0);
        end
        @(posedge clk_i);
        #1 y_force = 1'b0;

        // Eight commands against a stalled response port
        y_gate = 1'b0; rsp_ready_i = 1'b0; base = got_n;
        fork
            begin
                for (int i = 0; i < 8; i++) send(tv_a[i], tv_b[i]);
            end
            begin
                repeat (8) @(negedge clk_i);
                check("t2_outst_full", 32'(outst_o), 4);
                check("t2_cmd_ready",  32'(cmd_ready_o), 0);
                check("t2_a_en",       32'(a_en_o), 0);
                check("t2_no_rsp",     32'(rsp_valid_o), 0);
                y_gate = 1'b1;
                repeat (4) @(negedge clk_i);
                check("t2_rsp_valid",  32'(rsp_valid_o), 1);
                check("t2_rsp_a",      32'(rsp_a_o), 12);
                check("t2_rsp_b",      32'(rsp_b_o), 8);
                check("t2_rsp_y",      32'(rsp_y_o), 4);
                check("t2_outst_hold", 32'(outst_o), 4);
                check("t2_y_en_block", 32'(y_en_o), 0);
                rsp_ready_i = 1'b1;
                wait_rsp(base + 8);
            end
        join
        for (int i = 0; i < 8; i++) check_got($sformatf("t2_drain%0d", i), base + i, tv_a[i], tv_b[i], tv_y[i]);
        check("t2_outst_end", 32'(outst_o), 0);

        // Watchdog: result withheld for more than TIMEOUT_CYC cycles
        @(posedge clk_i);
        #1 y_gate = 1'b0; base = got_n;
        send(4'd9, 4'd6);
        repeat (5) @(negedge clk_i);
        check("t5_timeout_early", 32'(timeout_o), 0);
        repeat (10) @(negedge clk_i);
`ifdef GCD_HOST_TIMEOUT_EN
        check("t5_timeout_set", 32'(timeout_o), 1);
`else
        check("t5_timeout_off", 32'(timeout_o), 0);
`endif
        y_gate = 1'b1;
        wait_rsp(base + 1);
        check_got("t5", base, 4'd9, 4'd6, 4'd3);
`ifdef GCD_HOST_TIMEOUT_EN
        check("t5_timeout_sticky", 32'(timeout_o), 1);
`else
        check("t5_timeout_still0", 32'(timeout_o), 0);
`endif

        // Reset mid-operation
        @(posedge clk_i);
        #1 y_gate = 1'b0; rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(tv_a[i], tv_b[i]);
        y_gate = 1'b1;
        @(posedge clk_i);
        #1 y_gate = 1'b0;
        @(negedge clk_i);
        check("t6_pre_outst", 32'(outst_o), 3);
        check("t6_pre_rsp",   32'(rsp_valid_o), 1);
        #2 rst_ni = 1'b0; a_rdy_i = 1'b0; b_rdy_i = 1'b0;
        #1;
        check("t6_rsp_valid", 32'(rsp_valid_o), 0);
        check("t6_rsp_a",     32'(rsp_a_o), 0);
        check("t6_rsp_b",     32'(rsp_b_o), 0);
        check("t6_rsp_y",     32'(rsp_y_o), 0);
        check("t6_outst",     32'(outst_o), 0);
        check("t6_timeout",   32'(timeout_o), 0);
        check("t6_a_data",    32'(a_data_o), 0);
        check("t6_b_data",    32'(b_data_o), 0);
        check("t6_cmd_ready", 32'(cmd_ready_o), 0);
        check("t6_y_en",      32'(y_en_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1; a_rdy_i = 1'b1; b_rdy_i = 1'b1; rsp_ready_i = 1'b1; y_gate = 1'b1;
        base = got_n;
        send(4'd10, 4'd4);
        wait_rsp(base + 1);
        check_got("t6_post", base, 4'd10, 4'd4, 4'd2);
        check("t6_post_outst", 32'(outst_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
